// File: rtl/afe4490_pkg.sv
// afe4490_pkg
//   Shared definitions for the AFE4490 transaction sequencer: AFE register
//   addresses, CONTROL0 bit constants, the init-table entry type and the
//   sequencer state encoding.
package afe4490_pkg;

    // AFE4490 register map (subset used by the sequencer and its init table)
    localparam logic [7:0] REG_CONTROL0    = 8'h00;
    localparam logic [7:0] REG_LED2STC     = 8'h01;
    localparam logic [7:0] REG_LED2ENDC    = 8'h02;
    localparam logic [7:0] REG_LED2LEDSTC  = 8'h03;
    localparam logic [7:0] REG_LED2LEDENDC = 8'h04;
    localparam logic [7:0] REG_ALED2STC    = 8'h05;
    localparam logic [7:0] REG_ALED2ENDC   = 8'h06;
    localparam logic [7:0] REG_LED1STC     = 8'h07;
    localparam logic [7:0] REG_LED1ENDC    = 8'h08;
    localparam logic [7:0] REG_LED1LEDSTC  = 8'h09;
    localparam logic [7:0] REG_LED1LEDENDC = 8'h0A;
    localparam logic [7:0] REG_ALED1STC    = 8'h0B;
    localparam logic [7:0] REG_PRPCOUNT    = 8'h1D;
    localparam logic [7:0] REG_CONTROL1    = 8'h1E;
    localparam logic [7:0] REG_TIAGAIN     = 8'h20;
    localparam logic [7:0] REG_LEDCNTRL    = 8'h22;
    localparam logic [7:0] REG_CONTROL2    = 8'h23;
    localparam logic [7:0] REG_LED2VAL     = 8'h2A;
    localparam logic [7:0] REG_ALED2VAL    = 8'h2B;
    localparam logic [7:0] REG_LED1VAL     = 8'h2C;
    localparam logic [7:0] REG_ALED1VAL    = 8'h2D;
    localparam logic [7:0] REG_DIAG        = 8'h30;

    // CONTROL0 bits
    localparam int CTRL0_SPI_READ_BIT = 0;
    localparam int CTRL0_SW_RST_BIT   = 3;

    localparam logic [23:0] CTRL0_SPI_READ = 24'(1) << CTRL0_SPI_READ_BIT;
    localparam logic [23:0] CTRL0_SW_RST   = 24'(1) << CTRL0_SW_RST_BIT;

    typedef struct packed {
        logic [7:0]  addr;
        logic [23:0] data;
    } init_entry_t;

    typedef enum logic [3:0] {
        IDLE,
        SWRST_ISSUE,
        SWRST_WAIT,
        INIT_ISSUE,
        INIT_WAIT,
        RUN_WAIT,
        EN_ISSUE,
        EN_WAIT,
        RD_ISSUE,
        RD_WAIT,
        DIS_ISSUE,
        DIS_WAIT,
        PUBLISH
    } seq_state_t;

endpackage

// File: rtl/afe4490_init_rom.sv
// afe4490_init_rom
//   Combinational init table written to the AFE after soft reset.
//   Timing windows first, then PRPCOUNT and analog front-end setup, with
//   CONTROL1 last so the AFE timer only starts once everything is programmed.
// Ports
//   index  in   7   table index
//   entry  out  32  {addr[7:0], data[23:0]}
module afe4490_init_rom
    import afe4490_pkg::*;
(
    input  logic [6:0]  index,
    output init_entry_t entry
);

    always_comb begin
        entry = '{addr: REG_CONTROL0, data: 24'h000000};
        case (index)
            7'd0:  entry = '{addr: REG_LED2STC,     data: 24'd6050};
            7'd1:  entry = '{addr: REG_LED2ENDC,    data: 24'd7998};
            7'd2:  entry = '{addr: REG_LED2LEDSTC,  data: 24'd6000};
            7'd3:  entry = '{addr: REG_LED2LEDENDC, data: 24'd7999};
            7'd4:  entry = '{addr: REG_ALED2STC,    data: 24'd50};
            7'd5:  entry = '{addr: REG_ALED2ENDC,   data: 24'd1998};
            7'd6:  entry = '{addr: REG_LED1STC,     data: 24'd2050};
            7'd7:  entry = '{addr: REG_LED1ENDC,    data: 24'd3998};
            7'd8:  entry = '{addr: REG_LED1LEDSTC,  data: 24'd2000};
            7'd9:  entry = '{addr: REG_LED1LEDENDC, data: 24'd3999};
            7'd10: entry = '{addr: REG_ALED1STC,    data: 24'd4050};
            7'd11: entry = '{addr: REG_PRPCOUNT,    data: 24'd7999};
            7'd12: entry = '{addr: REG_TIAGAIN,     data: 24'h000005};
            7'd13: entry = '{addr: REG_LEDCNTRL,    data: 24'h011414};
            7'd14: entry = '{addr: REG_CONTROL2,    data: 24'h000000};
            7'd15: entry = '{addr: REG_CONTROL1,    data: 24'h000102};
            // Beyond the defined table: a CONTROL0 write of zero is harmless.
            default: entry = '{addr: REG_CONTROL0,  data: 24'h000000};
        endcase
    end

endmodule

// File: rtl/afe4490_sequencer.sv
// afe4490_sequencer
//   Drives the AFE4490 SPI engine: soft reset + init table on i_start, then
//   on each ADC_RDY rising edge enables SPI_READ, reads the four sample
//   registers, disables SPI_READ and publishes the sample set.
// Ports
//   i_clk, i_rst              clock, async active-high reset
//   i_start                   pulse: (re)run soft reset + init (IDLE/RUN_WAIT only)
//   i_adc_rdy                 asynchronous ADC_RDY pin
//   o_addr/o_wr_data/o_rd_wr  transaction fields, held from o_dv until i_done
//   o_dv                      1-cycle transaction request
//   i_done/i_rd_data          transaction complete / read data
//   o_init_done               level: init finished, sampling armed
//   o_led2/o_aled2/o_led1/o_aled1  sign-extended 22-bit sample words
//   o_sample_valid            1-cycle pulse when the four samples update
//   o_overrun, o_error        sticky flags, cleared by an accepted i_start
module afe4490_sequencer
    import afe4490_pkg::*;
#(
    parameter int INIT_LEN     = 16,
    parameter int DONE_TIMEOUT = 4096,
    parameter int SYNC_STAGES  = 2
)(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_adc_rdy,
    output logic [7:0]  o_addr,
    output logic [23:0] o_wr_data,
    output logic        o_rd_wr,
    output logic        o_dv,
    input  logic        i_done,
    input  logic [23:0] i_rd_data,
    output logic        o_init_done,
    output logic [23:0] o_led2,
    output logic [23:0] o_aled2,
    output logic [23:0] o_led1,
    output logic [23:0] o_aled1,
    output logic        o_sample_valid,
    output logic        o_overrun,
    output logic        o_error
);

    localparam int TW = $clog2(DONE_TIMEOUT + 1);

    seq_state_t       state, state_next;
    logic [SYNC_STAGES-1:0] rdy_sync;
    logic             rdy_prev;
    logic             rdy_edge;
    logic [6:0]       init_idx;
    logic [1:0]       rd_idx;
    logic [23:0]      shadow [4];
    logic [TW-1:0]    tmo_cnt;
    logic             is_issue, is_wait, readout_busy;
    logic             tmo_hit, start_ok, last_init;
    logic [23:0]      rd_word;
    logic [1:0]       unused_rd_top;
    init_entry_t      rom_entry;

    afe4490_init_rom u_rom (
        .index (init_idx),
        .entry (rom_entry)
    );

    assign is_issue = state inside {SWRST_ISSUE, INIT_ISSUE, EN_ISSUE, RD_ISSUE, DIS_ISSUE};
    assign is_wait  = state inside {SWRST_WAIT, INIT_WAIT, EN_WAIT, RD_WAIT, DIS_WAIT};
    assign readout_busy = state inside {EN_ISSUE, EN_WAIT, RD_ISSUE, RD_WAIT,
                                        DIS_ISSUE, DIS_WAIT, PUBLISH};
    assign start_ok  = i_start && (state == IDLE || state == RUN_WAIT);
    assign last_init = (init_idx == 7'(INIT_LEN - 1));
    // A done arriving on the final count still completes the transaction.
    assign tmo_hit   = is_wait && !i_done && (tmo_cnt == TW'(DONE_TIMEOUT - 1));
    assign rdy_edge  = rdy_sync[SYNC_STAGES-1] && !rdy_prev;

    // The AFE returns 22-bit two's complement; the top two bits are don't-care.
    assign rd_word       = {{2{i_rd_data[21]}}, i_rd_data[21:0]};
    assign unused_rd_top = i_rd_data[23:22];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdy_sync <= '0;
            rdy_prev <= 1'b0;
        end else begin
            rdy_sync <= {rdy_sync[SYNC_STAGES-2:0], i_adc_rdy};
            rdy_prev <= rdy_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    // i_start beats a simultaneous ADC_RDY edge in RUN_WAIT; a timeout
    // overrides whatever the current state would have done.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (start_ok) state_next = SWRST_ISSUE;
            SWRST_ISSUE: state_next = SWRST_WAIT;
            SWRST_WAIT:  if (i_done) state_next = INIT_ISSUE;
            INIT_ISSUE:  state_next = INIT_WAIT;
            INIT_WAIT:   if (i_done) state_next = last_init ? RUN_WAIT : INIT_ISSUE;
            RUN_WAIT: begin
                if (start_ok)      state_next = SWRST_ISSUE;
                else if (rdy_edge) state_next = EN_ISSUE;
            end
            EN_ISSUE:    state_next = EN_WAIT;
            EN_WAIT:     if (i_done) state_next = RD_ISSUE;
            RD_ISSUE:    state_next = RD_WAIT;
            RD_WAIT:     if (i_done) state_next = (rd_idx == 2'd3) ? DIS_ISSUE : RD_ISSUE;
            DIS_ISSUE:   state_next = DIS_WAIT;
            DIS_WAIT:    if (i_done) state_next = PUBLISH;
            PUBLISH:     state_next = RUN_WAIT;
            default:     state_next = IDLE;
        endcase
        if (tmo_hit) state_next = IDLE;
    end

    // Transaction fields decode from the state pair, so they stay stable
    // from the ISSUE cycle through the whole WAIT.
    always_comb begin
        o_addr    = '0;
        o_wr_data = '0;
        o_rd_wr   = 1'b0;
        case (state)
            SWRST_ISSUE, SWRST_WAIT: begin
                o_addr    = REG_CONTROL0;
                o_wr_data = CTRL0_SW_RST;
            end
            INIT_ISSUE, INIT_WAIT: begin
                o_addr    = rom_entry.addr;
                o_wr_data = rom_entry.data;
            end
            EN_ISSUE, EN_WAIT: begin
                o_addr    = REG_CONTROL0;
                o_wr_data = CTRL0_SPI_READ;
            end
            RD_ISSUE, RD_WAIT: begin
                o_addr  = REG_LED2VAL + 8'(rd_idx);
                o_rd_wr = 1'b1;
            end
            DIS_ISSUE, DIS_WAIT: begin
                o_addr    = REG_CONTROL0;
                o_wr_data = '0;
            end
            default: ;
        endcase
        o_dv = is_issue;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tmo_cnt        <= '0;
            init_idx       <= '0;
            rd_idx         <= '0;
            for (int i = 0; i < 4; i++) shadow[i] <= '0;
            o_led2         <= '0;
            o_aled2        <= '0;
            o_led1         <= '0;
            o_aled1        <= '0;
            o_sample_valid <= 1'b0;
            o_init_done    <= 1'b0;
            o_overrun      <= 1'b0;
            o_error        <= 1'b0;
        end else begin
            o_sample_valid <= 1'b0;

            if (is_issue)     tmo_cnt <= '0;
            else if (is_wait) tmo_cnt <= tmo_cnt + 1'b1;

            if (start_ok) begin
                init_idx    <= '0;
                o_init_done <= 1'b0;
                o_overrun   <= 1'b0;
                o_error     <= 1'b0;
            end

            if (state == INIT_WAIT && i_done) begin
                if (last_init) o_init_done <= 1'b1;
                else           init_idx    <= init_idx + 7'd1;
            end

            if (state == RUN_WAIT) rd_idx <= '0;

            if (state == RD_WAIT && i_done) begin
                shadow[rd_idx] <= rd_word;
                rd_idx         <= rd_idx + 2'd1;
            end

            // All four outputs move together with the valid pulse.
            if (state == DIS_WAIT && i_done) begin
                o_led2         <= shadow[0];
                o_aled2        <= shadow[1];
                o_led1         <= shadow[2];
                o_aled1        <= shadow[3];
                o_sample_valid <= 1'b1;
            end

            if (rdy_edge && readout_busy) o_overrun <= 1'b1;

            if (tmo_hit) begin
                o_error     <= 1'b1;
                o_init_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_afe4490_sequencer.sv
// tb_afe4490_sequencer
//   Directed bench for afe4490_sequencer with an SPI engine model that answers
//   each o_dv with i_done SPI_LATENCY cycles later. Expected transactions and
//   sample sets are queued as stimulus is applied and popped as the DUT acts.
module tb_afe4490_sequencer;

    localparam int INIT_LEN     = 16;
    localparam int DONE_TIMEOUT = 4096;
    localparam int SYNC_STAGES  = 2;
    localparam int SPI_LATENCY  = 40;
    localparam int TXN_CYCLES   = SPI_LATENCY + 5;

    localparam logic [31:0] INIT_TABLE [INIT_LEN] = '{
        {8'h01, 24'd6050}, {8'h02, 24'd7998}, {8'h03, 24'd6000}, {8'h04, 24'd7999},
        {8'h05, 24'd50},   {8'h06, 24'd1998}, {8'h07, 24'd2050}, {8'h08, 24'd3998},
        {8'h09, 24'd2000}, {8'h0A, 24'd3999}, {8'h0B, 24'd4050}, {8'h1D, 24'd7999},
        {8'h20, 24'h000005}, {8'h22, 24'h011414}, {8'h23, 24'h000000}, {8'h1E, 24'h000102}
    };

    typedef struct packed {
        logic [7:0]  addr;
        logic [23:0] data;
        logic        rd;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        adc_rdy;
    logic [7:0]  addr;
    logic [23:0] wr_data;
    logic        rd_wr;
    logic        dv;
    logic        done;
    logic [23:0] rd_data;
    logic        init_done;
    logic [23:0] led2, aled2, led1, aled1;
    logic        sample_valid;
    logic        overrun;
    logic        error;

    logic        hold_done;
    logic [23:0] rd_val [4];

    txn_t        exp_txn [$];
    logic [95:0] exp_smp [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          sample_seen = 0;

    afe4490_sequencer #(
        .INIT_LEN     (INIT_LEN),
        .DONE_TIMEOUT (DONE_TIMEOUT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_adc_rdy      (adc_rdy),
        .o_addr         (addr),
        .o_wr_data      (wr_data),
        .o_rd_wr        (rd_wr),
        .o_dv           (dv),
        .i_done         (done),
        .i_rd_data      (rd_data),
        .o_init_done    (init_done),
        .o_led2         (led2),
        .o_aled2        (aled2),
        .o_led1         (led1),
        .o_aled1        (aled1),
        .o_sample_valid (sample_valid),
        .o_overrun      (overrun),
        .o_error        (error)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] readValue(input logic [7:0] a);
        case (a)
            8'h2A:   return rd_val[0];
            8'h2B:   return rd_val[1];
            8'h2C:   return rd_val[2];
            8'h2D:   return rd_val[3];
            default: return 24'h000000;
        endcase
    endfunction

    // SPI engine model
    logic       model_busy;
    int         model_cnt;
    logic [7:0] model_addr;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
            model_addr <= '0;
            done       <= 1'b0;
            rd_data    <= '0;
        end else begin
            done <= 1'b0;
            if (model_busy) begin
                if (model_cnt == SPI_LATENCY - 1) begin
                    model_busy <= 1'b0;
                    done       <= 1'b1;
                    rd_data    <= readValue(model_addr);
                end else begin
                    model_cnt <= model_cnt + 1;
                end
            end else if (dv && !hold_done) begin
                model_busy <= 1'b1;
                model_cnt  <= 1;
                model_addr <= addr;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic sampleBus();
        txn_t        t;
        logic [95:0] s;
        if (dv) begin
            if (exp_txn.size() == 0) begin
                checkOutput("extra_dv", 64'(dv), 64'd0);
            end else begin
                t = exp_txn.pop_front();
                checkOutput("txn_addr_dir", {55'd0, rd_wr, addr}, {55'd0, t.rd, t.addr});
                if (!t.rd) checkOutput("txn_wr_data", 64'(wr_data), 64'(t.data));
            end
        end
        if (sample_valid) begin
            sample_seen++;
            if (exp_smp.size() == 0) begin
                checkOutput("extra_sample_valid", 64'(sample_valid), 64'd0);
            end else begin
                s = exp_smp.pop_front();
                checkOutput("sample_led2_aled2", {16'd0, led2, aled2}, {16'd0, s[95:48]});
                checkOutput("sample_led1_aled1", {16'd0, led1, aled1}, {16'd0, s[47:0]});
            end
        end
    endtask

    // One clock of inputs; i_start is always a single-cycle pulse.
    task automatic applyStimulus(input logic start_pulse, input logic rdy_level);
        @(negedge clk);
        sampleBus();
        start   = start_pulse;
        adc_rdy = rdy_level;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic watchBus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            sampleBus();
        end
    endtask

    task automatic pushTxn(input logic [7:0] a, input logic [23:0] d, input logic r);
        txn_t t;
        t.addr = a;
        t.data = d;
        t.rd   = r;
        exp_txn.push_back(t);
    endtask

    task automatic pushInit();
        pushTxn(8'h00, 24'h000008, 1'b0);
        for (int i = 0; i < INIT_LEN; i++) pushTxn(INIT_TABLE[i][31:24], INIT_TABLE[i][23:0], 1'b0);
    endtask

    task automatic pushReadout(input logic [95:0] smp);
        pushTxn(8'h00, 24'h000001, 1'b0);
        pushTxn(8'h2A, 24'h000000, 1'b1);
        pushTxn(8'h2B, 24'h000000, 1'b1);
        pushTxn(8'h2C, 24'h000000, 1'b1);
        pushTxn(8'h2D, 24'h000000, 1'b1);
        pushTxn(8'h00, 24'h000000, 1'b0);
        exp_smp.push_back(smp);
    endtask

    initial begin
        int n;
        int smp_before;

        rst       = 1'b1;
        start     = 1'b0;
        adc_rdy   = 1'b0;
        hold_done = 1'b0;
        for (int i = 0; i < 4; i++) rd_val[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_bus", {31'd0, dv, rd_wr, addr, wr_data}, 64'd0);
        checkOutput("reset_flags", {60'd0, init_done, sample_valid, overrun, error}, 64'd0);
        checkOutput("reset_samples_a", {16'd0, led2, aled2}, 64'd0);
        checkOutput("reset_samples_b", {16'd0, led1, aled1}, 64'd0);
        rst = 1'b0;

        // Soft reset + init table; an ADC_RDY edge mid-init is ignored
        $display("[TB] init sequence");
        pushInit();
        applyStimulus(1'b1, 1'b0);
        watchBus(100);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        watchBus((INIT_LEN + 1) * TXN_CYCLES - 100);
        checkOutput("init_txns_drained", 64'(exp_txn.size()), 64'd0);
        checkOutput("init_done_set", 64'(init_done), 64'd1);
        checkOutput("no_overrun_during_init", 64'(overrun), 64'd0);

        // First readout with sign-extension corner values
        $display("[TB] first readout");
        rd_val[0] = 24'h3FFFFF;
        rd_val[1] = 24'h200000;
        rd_val[2] = 24'h000123;
        rd_val[3] = 24'hC00001;
        smp_before = sample_seen;
        pushReadout({24'hFFFFFF, 24'hE00000, 24'h000123, 24'h000001});
        applyStimulus(1'b0, 1'b1);
        watchBus(6 * TXN_CYCLES + 10);
        checkOutput("readout1_txns_drained", 64'(exp_txn.size()), 64'd0);
        checkOutput("readout1_valid_count", 64'(sample_seen - smp_before), 64'd1);
        checkOutput("readout1_no_overrun", 64'(overrun), 64'd0);

        // Second edge arriving mid-readout is dropped and flagged
        $display("[TB] overrun readout");
        rd_val[0] = 24'h155555;
        rd_val[1] = 24'h2ABCDE;
        rd_val[2] = 24'hFFFFFE;
        rd_val[3] = 24'h400010;
        smp_before = sample_seen;
        applyStimulus(1'b0, 1'b0);
        pushReadout({24'h155555, 24'hEABCDE, 24'hFFFFFE, 24'h000010});
        applyStimulus(1'b0, 1'b1);
        watchBus(100);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        watchBus(250);
        checkOutput("overrun_set", 64'(overrun), 64'd1);
        checkOutput("overrun_txns_drained", 64'(exp_txn.size()), 64'd0);
        checkOutput("overrun_single_valid", 64'(sample_seen - smp_before), 64'd1);

        // i_start and ADC_RDY edge land on the same clock in RUN_WAIT
        $display("[TB] start vs edge");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
        smp_before = sample_seen;
        pushInit();
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("start_clears_init_done", 64'(init_done), 64'd0);
        checkOutput("start_clears_overrun", 64'(overrun), 64'd0);
        watchBus((INIT_LEN + 1) * TXN_CYCLES);
        checkOutput("reinit_txns_drained", 64'(exp_txn.size()), 64'd0);
        checkOutput("reinit_done", 64'(init_done), 64'd1);
        checkOutput("reinit_no_overrun", 64'(overrun), 64'd0);
        checkOutput("reinit_no_sample", 64'(sample_seen - smp_before), 64'd0);

        // SPI engine never answers: timeout
        $display("[TB] timeout");
        hold_done = 1'b1;
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        checkOutput("timeout_swrst_req", {31'd0, dv, rd_wr, addr, wr_data},
                    {31'd0, 1'b1, 1'b0, 8'h00, 24'h000008});
        n = 0;
        while (!error && n < DONE_TIMEOUT + 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_latency", 64'(n), 64'(DONE_TIMEOUT + 1));
        checkOutput("timeout_error_set", 64'(error), 64'd1);
        checkOutput("timeout_init_done_clear", 64'(init_done), 64'd0);
        watchBus(20);
        hold_done = 1'b0;
        pushInit();
        applyStimulus(1'b1, 1'b0);
        checkOutput("start_clears_error", 64'(error), 64'd0);
        watchBus((INIT_LEN + 1) * TXN_CYCLES);
        checkOutput("post_timeout_init_done", 64'(init_done), 64'd1);
        checkOutput("post_timeout_drained", 64'(exp_txn.size()), 64'd0);

        // Async reset in the middle of the first sample read
        $display("[TB] reset mid-read");
        pushTxn(8'h00, 24'h000001, 1'b0);
        pushTxn(8'h2A, 24'h000000, 1'b1);
        applyStimulus(1'b0, 1'b1);
        watchBus(70);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_bus_cleared", {31'd0, dv, rd_wr, addr, wr_data}, 64'd0);
        checkOutput("rst_flags_cleared", {60'd0, init_done, sample_valid, overrun, error}, 64'd0);
        checkOutput("rst_samples_cleared", {16'd0, led2, aled2}, 64'd0);
        checkOutput("rst_partial_drained", 64'(exp_txn.size()), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        adc_rdy = 1'b0;
        pushInit();
        applyStimulus(1'b1, 1'b0);
        watchBus((INIT_LEN + 1) * TXN_CYCLES);
        checkOutput("post_reset_init_done", 64'(init_done), 64'd1);
        checkOutput("post_reset_drained", 64'(exp_txn.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
